// File: rtl/div_pkg.sv
// Shared types and defaults for the repeated-subtraction divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LDB,
    S_SUB,
    S_DONE
  } div_state_t;

endpackage

// File: rtl/div_repsub_if.sv
// Start/busy/done handshake plus shared operand bus and result bus of the divider.
interface div_repsub_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, data_in,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, data_in,
    output busy, done, div_by_zero, quotient, remainder
  );

endinterface

// File: rtl/div_datapath.sv
// Remainder, divisor and quotient registers with the compare and zero-detect
// status bits consumed by the divider controller.
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_a_i,
  input  logic             load_b_i,
  input  logic             sub_i,
  output logic             ge_o,
  output logic             bz_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    // NOTE: hold values are assigned first so every path drives every signal; no latches.
    r_d = r_q;
    d_d = d_q;
    q_d = q_q;
    if (load_a_i) begin
      r_d = data_i;
      q_d = '0;
    end else if (sub_i) begin
      r_d = r_q - d_q;
      q_d = q_q + WIDTH'(1);
    end
    if (load_b_i) begin
      d_d = data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else begin
      r_q <= r_d;
      d_q <= d_d;
      q_q <= q_d;
    end
  end

  assign ge_o  = (r_q >= d_q);
  assign bz_o  = (data_i == '0);
  assign rem_o = r_q;
  assign quo_o = q_q;

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction: controller FSM around div_datapath,
// one subtraction per clock, quotient counted in the datapath.
module div_repsub
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  div_repsub_if.slave  bus
);

  div_state_t state_q, state_d;
  logic       err_q, err_d;
  logic       ge, bz;
  logic       load_a, load_b, sub_en;
  logic       busy, done;
  logic [WIDTH-1:0] rem, quo;

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (bus.data_in),
    .load_a_i (load_a),
    .load_b_i (load_b),
    .sub_i    (sub_en),
    .ge_o     (ge),
    .bz_o     (bz),
    .rem_o    (rem),
    .quo_o    (quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_LDB;
      S_LDB:  state_d = bz ? S_DONE : S_SUB;
      S_SUB:  if (!ge) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_a = (state_q == S_IDLE) && bus.start;
    load_b = (state_q == S_LDB);
    sub_en = (state_q == S_SUB) && ge;
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
  end

  // The error flag survives the done pulse and is only cleared by an accepted start.
  always_comb begin
    err_d = err_q;
    if (load_a) begin
      err_d = 1'b0;
    end else if (load_b && bz) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = err_q;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;

endmodule

// File: tb/tb_div_repsub.sv
// Scoreboard bench for div_repsub: the driver pushes expected results from an
// arithmetic model, an independent monitor pops and compares on every done.
module tb_div_repsub;
  import div_pkg::*;

  localparam int W = 16;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned err;
    int unsigned lat;
    int unsigned c0;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_repsub_if #(.WIDTH(W)) bus ();

  div_repsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          errors   = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain integer division; latency is count of subtractions plus load, fail-compare and done.
  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned c0);
    exp_t e;
    e.c0 = c0;
    if (b == 0) begin
      e.q = 0; e.r = a; e.err = 1; e.lat = 2;
    end else begin
      e.q = a / b; e.r = a % b; e.err = 0; e.lat = a / b + 3;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient",    32'(bus.quotient),    mon_e.q);
        check("remainder",   32'(bus.remainder),   mon_e.r);
        check("div_by_zero", 32'(bus.div_by_zero), mon_e.err);
        check("latency",     cyc - mon_e.c0,       mon_e.lat);
        check("busy_at_done", 32'(bus.busy),       32'd1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy),        32'd0);
    check({tag, "_done"},  32'(bus.done),        32'd0);
    check({tag, "_dbz"},   32'(bus.div_by_zero), 32'd0);
    check({tag, "_quo"},   32'(bus.quotient),    32'd0);
    check({tag, "_rem"},   32'(bus.remainder),   32'd0);
  endtask

  // pulse_at: cycle index at which a stray start is driven; rst_at: cycle index of a reset.
  task automatic run_div(input int unsigned a, input int unsigned b,
                         input int pulse_at = -1, input int unsigned pulse_val = 0,
                         input int rst_at = -1);
    exp_t        e;
    int unsigned n0;
    int          k;
    bit          timed_out;
    timed_out = 1'b0;
    @(negedge clk); #1;
    bus.start   = 1'b1;
    bus.data_in = W'(a);
    e  = model(a, b, cyc);
    sb.push_back(e);
    n0 = done_cnt;
    @(negedge clk); #1;
    bus.start   = 1'b0;
    bus.data_in = W'(b);
    check("busy_cycle1", 32'(bus.busy), 32'd1);
    while (1) begin
      @(negedge clk); #1;
      k = int'(cyc - e.c0);
      bus.data_in = W'($urandom);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        sb.delete();
        @(negedge clk); @(negedge clk);
        check("reset_no_done", 32'(done_cnt), n0);
        #1 rst_n = 1'b1;
        return;
      end
      if (done_cnt != n0) break;
      bus.start = (k == pulse_at);
      if (k == pulse_at) bus.data_in = W'(pulse_val);
      if (k > int'(e.lat) + 4) begin
        check("done_timeout", 32'd0, 32'd1);
        sb.delete();
        timed_out = 1'b1;
        break;
      end
    end
    bus.start = ($urandom_range(0, 1) == 1);
    @(negedge clk); #1;
    bus.start = 1'b0;
    check("idle_after_done", 32'(bus.busy), 32'd0);
    if (!timed_out) check("quotient_held", 32'(bus.quotient), e.q);
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned a, b;
    bus.start   = 1'b0;
    bus.data_in = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk); #1 rst_n = 1'b1;

    run_div(100, 7);
    run_div(5, 9);
    run_div(0, 3);
    run_div(1234, 0);
    run_div(50, 5);
    run_div(65535, 1);
    run_div(200, 3, 10, 9);
    run_div(1000, 1, -1, 0, 20);
    run_div(9, 4);

    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 3000);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
      run_div(a, b, ($urandom_range(0, 1) == 1) ? 4 : -1, $urandom_range(0, 65535));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
